// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl -- pipeline sequencing controller for the 5-stage MIPS core.
//
// Drives the hold (stall) and zero (flush) inputs of the IF/ID, ID/EX, EX/MEM
// and MEM/WB pipeline registers. It resolves load-use hazards, taken-branch
// flushes and multi-cycle data-memory waits. It also counts stalled cycles and
// halts the pipe if the data memory stays busy for too long.
//
// Outputs are Mealy: they decode the state and the current inputs, so they
// are valid before the clock edge that they act on.
//
// Optional feature macro: PIPE_CTRL_FWD_EN
//   defined   -> forwarding exists, so only load-use hazards insert a bubble
//   undefined -> EX/MEM register writes that ID reads also insert a bubble
//
// Parameters:
//   TIMEOUT  consecutive dmem_busy cycles that force HALT (0 = never)
//   CW       width of stall_cycles
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   id_rs, id_rt             source registers of the instruction in ID
//   ex_memread, ex_rt        EX holds a load writing ex_rt
//   ex_regwrite, ex_rd       EX register write (no-forwarding build only)
//   mem_regwrite, mem_rd     MEM register write (no-forwarding build only)
//   mem_branch_taken         branch resolved taken in MEM
//   dmem_busy                data memory not ready this cycle
//   pc/ifid/idex/exmem_stall hold the PC / pipeline register
//   ifid/idex/exmem/memwb_zero  zero the pipeline register at the next edge
//   halted                   sticky memory-timeout indication
//   stall_cycles             saturating count of cycles with pc_stall=1
// -----------------------------------------------------------------------------
module pipe_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CW      = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [4:0]    id_rs,
  input  logic [4:0]    id_rt,
  input  logic          ex_memread,
  input  logic [4:0]    ex_rt,
  input  logic          ex_regwrite,
  input  logic [4:0]    ex_rd,
  input  logic          mem_regwrite,
  input  logic [4:0]    mem_rd,
  input  logic          mem_branch_taken,
  input  logic          dmem_busy,
  output logic          pc_stall,
  output logic          ifid_stall,
  output logic          idex_stall,
  output logic          exmem_stall,
  output logic          ifid_zero,
  output logic          idex_zero,
  output logic          exmem_zero,
  output logic          memwb_zero,
  output logic          halted,
  output logic [CW-1:0] stall_cycles
);

  typedef enum logic [1:0] {RUN, WAIT, HALT} state_t;

  // wait_cnt only has to reach TIMEOUT-1.
  localparam int WCW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT - 1);

  state_t         state, state_nxt;
  logic [WCW-1:0] wait_cnt, wait_cnt_nxt;
  logic           load_use, raw, hazard;

  // Register 0 is hard-wired to zero, so it never carries a dependency.
  assign load_use = ex_memread && (ex_rt != 5'd0) &&
                    ((ex_rt == id_rs) || (ex_rt == id_rt));

`ifdef PIPE_CTRL_FWD_EN
  // Forwarding covers ordinary RAW dependencies; these inputs are unused.
  logic unused_fwd;
  assign unused_fwd = ^{ex_regwrite, ex_rd, mem_regwrite, mem_rd};
  assign raw        = 1'b0;
`else
  assign raw = (ex_regwrite  && (ex_rd  != 5'd0) && ((ex_rd  == id_rs) || (ex_rd  == id_rt))) ||
               (mem_regwrite && (mem_rd != 5'd0) && ((mem_rd == id_rs) || (mem_rd == id_rt)));
`endif

  assign hazard = load_use || raw;

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    pc_stall     = 1'b0;
    ifid_stall   = 1'b0;
    idex_stall   = 1'b0;
    exmem_stall  = 1'b0;
    ifid_zero    = 1'b0;
    idex_zero    = 1'b0;
    exmem_zero   = 1'b0;
    memwb_zero   = 1'b0;
    halted       = 1'b0;

    unique case (state)
      RUN, WAIT: begin
        if (dmem_busy) begin
          // Freeze everything up to MEM and push a bubble into WB. A taken
          // branch in MEM is held there and flushed on the exit cycle.
          pc_stall    = 1'b1;
          ifid_stall  = 1'b1;
          idex_stall  = 1'b1;
          exmem_stall = 1'b1;
          memwb_zero  = 1'b1;
          if (state == RUN) begin
            state_nxt    = WAIT;
            wait_cnt_nxt = WCW'(1);
          end else if ((TIMEOUT != 0) && (wait_cnt == WAIT_LAST)) begin
            state_nxt = HALT;
          end else begin
            wait_cnt_nxt = wait_cnt + WCW'(1);
          end
        end else begin
          // The exit cycle of WAIT decodes exactly like RUN.
          if (mem_branch_taken) begin
            ifid_zero  = 1'b1;
            idex_zero  = 1'b1;
            exmem_zero = 1'b1;
          end else if (hazard) begin
            pc_stall   = 1'b1;
            ifid_stall = 1'b1;
            idex_zero  = 1'b1;
          end
          state_nxt    = RUN;
          wait_cnt_nxt = '0;
        end
      end
      HALT: begin
        pc_stall    = 1'b1;
        ifid_stall  = 1'b1;
        idex_stall  = 1'b1;
        exmem_stall = 1'b1;
        ifid_zero   = 1'b1;
        idex_zero   = 1'b1;
        exmem_zero  = 1'b1;
        memwb_zero  = 1'b1;
        halted      = 1'b1;
      end
      default: state_nxt = RUN;
    endcase

    // Reset has to flush the pipe registers even before the first edge.
    if (rst) begin
      pc_stall    = 1'b0;
      ifid_stall  = 1'b0;
      idex_stall  = 1'b0;
      exmem_stall = 1'b0;
      ifid_zero   = 1'b1;
      idex_zero   = 1'b1;
      exmem_zero  = 1'b1;
      memwb_zero  = 1'b1;
      halted      = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so that every
  // register samples its inputs from before the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (pc_stall && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + CW'(1);
    end
  end

endmodule
